axil_slv_regfile: RTL
=====================

Name: axil_slv_regfile

Overview:
AXI4-Lite responder (slave) exposing a bank of 32-bit read/write registers to a bus master, such as the master VIP used in the sensor IP example designs. This block is the peripheral-side register interface that sensor IPs (e.g. DHT11 control/data registers) sit behind. Register contents are driven out to the user logic, and a one-cycle write strobe marks each register update.

Parameters:
- DATA_W, 32, data bus width; only 32 is supported, 4 byte lanes.
- ADDR_W, 4, byte address width; register index is addr[ADDR_W-1:2].
- NUM_REGS, 4, number of implemented registers; 1 to 2^(ADDR_W-2).

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- reg_out  out  NUM_REGS*32  flattened register contents; reg i is at [32*i+31:32*i].
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe on the cycle after a register is written.

Behaviour:

Reset:
- reset is synchronous and active-high, with one clock.
- While reset is high, all registers go to 0 and all ready/valid outputs go low.
- bresp, rresp, rdata and reg_wr_pulse go to 0.
- Asserting reset mid-transaction discards any held AW, W, B or R state; no partial register write occurs.
- After reset releases, awready, wready and arready rise on the next cycle.

Write path (states W_IDLE, W_RESP):
- AW and W are accepted independently, in any order or in the same cycle.
- Each is latched into its own holding slot. awready is high while the AW slot is empty and the state is W_IDLE; wready works the same way for the W slot.
- When both slots are full, the write commits on the next edge:
  - Each register byte is updated where wstrb is set; other bytes keep their value.
  - reg_wr_pulse[idx] goes high for exactly one cycle.
  - bvalid rises, bresp is driven, and the state moves to W_RESP.
- Write latency: 1 cycle from the second of AW/W accepted to bvalid high.
- In W_RESP, bvalid holds until bready is sampled high. The state then returns to W_IDLE and both slots clear.
- No new AW or W is accepted while bvalid is high.
- wstrb = 0 still produces a response and a pulse, but the register is left unchanged.

Read path (states R_IDLE, R_DATA):
- arready is high in R_IDLE.
- On an AR handshake, rdata and rresp are registered and rvalid goes high on the next cycle; the state moves to R_DATA. Read latency is 1 cycle.
- rdata and rresp stay stable until rready is sampled high; arready is low in R_DATA.
- After the R handshake, the state returns to R_IDLE and arready goes high the next cycle. Peak throughput is therefore one read per 2 cycles.

Simultaneous events:
- The read and write paths are fully independent and may be active in the same cycle.
- If an AR handshake and a write commit target the same register on the same edge, the read returns the pre-write value.

Address decoding:
- addr[1:0] is ignored.
- An index >= NUM_REGS is out of range: a write to it changes nothing and produces no pulse, and a read of it returns rdata = 0.
- bresp and rresp are OKAY unless the error feature is enabled.

Optional Feature:
- Macro: AXIL_SLV_DECERR_EN.
- Defined: out-of-range accesses return SLVERR (2'b10) on bresp or rresp.
- Undefined: out-of-range accesses return OKAY (2'b00).
- In-range behaviour is identical in both builds.

Decomposition:
- Package axil_slv_pkg holds:
  - constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - the STRB_W = 4 localparam.
- One sub-module, axil_slv_regbank, holds register storage, the byte-strobe merge, reg_wr_pulse generation and the combinational read mux.
- The top level holds the two handshake FSMs and the holding slots.

Test Plan:
1. Sequential write/read: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC with wstrb = 0xF, then read back each address -> rdata matches the written value, all responses OKAY, and each reg_wr_pulse bit fires once.
2. Channel skew: assert W two cycles before AW (reg 1 = 0xDEADBEEF) -> wready handshakes first, bvalid appears 1 cycle after the AW handshake, and reg_out[63:32] = 0xDEADBEEF.
3. Byte strobe: with reg 2 = 0x11223344, write 0xAABBCCDD with wstrb = 0x5 -> reading reg 2 returns 0x11BB33DD.
4. Backpressure: hold bready and rready low for 5 cycles -> bvalid, rvalid and rdata stay stable, and awready, wready and arready stay low until the handshake completes.
5. Out of range: with NUM_REGS = 3, access 0xC -> rdata = 0 and no register changes; resp = 2'b10 with AXIL_SLV_DECERR_EN defined, 2'b00 without it.
6. Reset mid-write: accept AW, assert reset before W arrives, then send W only -> no register changes, no bvalid, all outputs are 0, and the next full write completes normally.

Source files
------------

// File: rtl/axil_slv_pkg.sv
// ============================================================================
// axil_slv_pkg : shared constants, FSM state types and byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package axil_slv_pkg;

    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0]       old_v,
        input logic [31:0]       new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [31:0] m;
        m = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_slv_regbank.sv
// ============================================================================
// axil_slv_regbank : register storage, byte-strobe merge, write pulses, read mux
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_slv_regbank
    import axil_slv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [STRB_W-1:0]          wr_strb_i,
    input  logic [IDX_W-1:0]           rd_idx_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [NUM_REGS*DATA_W-1:0] reg_out_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q;
    logic [NUM_REGS-1:0] w_hit;

    // An out-of-range index matches no register, so it writes nothing
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign w_hit[i] = wr_en_i && (wr_idx_i == IDX_W'(i));
        assign reg_out_o[DATA_W*i +: DATA_W] = regs_q[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pulse_q[i] <= w_hit[i];
                if (w_hit[i]) regs_q[i] <= strb_merge(regs_q[i], wr_data_i, wr_strb_i);
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_data_o = regs_q[i];
        end
    end

    assign wr_pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/axil_slv_regfile.sv
// ============================================================================
// axil_slv_regfile : AXI4-Lite responder over a bank of 32-bit registers
// Optional macro AXIL_SLV_DECERR_EN: out-of-range accesses answer SLVERR
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_slv_regfile
    import axil_slv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [STRB_W-1:0]          s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0] c_OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] c_OOR_RESP = RESP_OKAY;
`endif

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic              rdy_en_q;
    logic              aw_full_q, aw_full_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    logic [DATA_W-1:0] w_wr_data, w_rd_data;
    logic [STRB_W-1:0] w_wr_strb;
    logic              w_wr_in_range, w_rd_in_range;
    logic              w_unused_ok;

    // Readies stay low for the first cycle after reset releases
    assign s_axi_awready = rdy_en_q && (wr_state_q == W_IDLE) && !aw_full_q;
    assign s_axi_wready  = rdy_en_q && (wr_state_q == W_IDLE) && !w_full_q;
    assign s_axi_arready = rdy_en_q && (rd_state_q == R_IDLE);
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = (rd_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;

    // A handshake in this cycle bypasses its slot so the commit lands on the same edge
    assign w_wr_idx  = aw_full_q ? aw_idx_q : s_axi_awaddr[ADDR_W-1:2];
    assign w_wr_data = w_full_q  ? w_data_q : s_axi_wdata;
    assign w_wr_strb = w_full_q  ? w_strb_q : s_axi_wstrb;
    assign w_rd_idx  = s_axi_araddr[ADDR_W-1:2];

    assign w_wr_in_range = ({1'b0, w_wr_idx} < (IDX_W+1)'(NUM_REGS));
    assign w_rd_in_range = ({1'b0, w_rd_idx} < (IDX_W+1)'(NUM_REGS));

    assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        w_commit   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_idx_d  = s_axi_awaddr[ADDR_W-1:2];
                end
                if (w_w_hs) begin
                    w_full_d = 1'b1;
                    w_data_d = s_axi_wdata;
                    w_strb_d = s_axi_wstrb;
                end
                if ((aw_full_q || w_aw_hs) && (w_full_q || w_w_hs)) begin
                    w_commit   = 1'b1;
                    wr_state_d = W_RESP;
                    bresp_d    = w_wr_in_range ? RESP_OKAY : c_OOR_RESP;
                    aw_full_d  = 1'b0;
                    w_full_d   = 1'b0;
                end
            end
            W_RESP: begin
                if (s_axi_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rd_state_d = R_DATA;
                    rdata_d    = w_rd_data;
                    rresp_d    = w_rd_in_range ? RESP_OKAY : c_OOR_RESP;
                end
            end
            R_DATA: begin
                if (s_axi_rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            rdy_en_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            rdy_en_q   <= 1'b1;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Read mux sees the pre-commit contents, so a colliding read returns the old value
    axil_slv_regbank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regbank (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (w_commit),
        .wr_idx_i   (w_wr_idx),
        .wr_data_i  (w_wr_data),
        .wr_strb_i  (w_wr_strb),
        .rd_idx_i   (w_rd_idx),
        .rd_data_o  (w_rd_data),
        .reg_out_o  (reg_out),
        .wr_pulse_o (reg_wr_pulse)
    );

endmodule

`default_nettype wire
